// File: rtl/dram_cmd_fsm.sv
// Single-request DRAM command sequencer: walks one mapped request through
// PRE/ACT/RD/WR under tRP, tRCD, tRAS and data-latency timing, then pulses done.
module dram_cmd_fsm #(
  parameter int BANK_W  = 4,
  parameter int ROW_W   = 16,
  parameter int COL_W   = 10,
  parameter int T_RCD   = 4,
  parameter int T_RP    = 4,
  parameter int T_RAS   = 10,
  parameter int T_CL    = 4,
  parameter int T_BURST = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [BANK_W-1:0] req_bank,
  input  logic [ROW_W-1:0]  req_row,
  input  logic [COL_W-1:0]  req_col,
  input  logic [1:0]        row_stat,
  output logic [2:0]        cmd,
  output logic [BANK_W-1:0] cmd_bank,
  output logic [ROW_W-1:0]  cmd_row,
  output logic [COL_W-1:0]  cmd_col,
  output logic              done,
  output logic              busy
);

  localparam int DATA_CYC = T_CL + T_BURST;
  localparam int MAX_A    = (T_RAS > DATA_CYC) ? T_RAS : DATA_CYC;
  localparam int MAX_B    = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RP_LOAD   = CNT_W'(T_RP - 2);
  localparam logic [CNT_W-1:0] RCD_LOAD  = CNT_W'(T_RCD - 2);
  localparam logic [CNT_W-1:0] RAS_LOAD  = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_RP,
    S_ACT,
    S_WAIT_RCD,
    S_RW,
    S_WAIT_DATA
  } state_e;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4
  } cmd_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   ras_q, ras_d;
  logic               rw_q, rw_d;
  logic [BANK_W-1:0]  bank_q, bank_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [BANK_W-1:0]  last_bank_q;
  logic [ROW_W-1:0]   last_row_q;
  logic [COL_W-1:0]   last_col_q;
  cmd_e               cmd_c;
  logic               done_c;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned; otherwise always_comb would infer a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ras_d   = (ras_q == '0) ? '0 : ras_q - CNT_ONE;
    rw_d    = rw_q;
    bank_d  = bank_q;
    row_d   = row_q;
    col_d   = col_q;
    cmd_c   = CMD_NOP;
    done_c  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rw_d   = req_rw;
          bank_d = req_bank;
          row_d  = req_row;
          col_d  = req_col;
          unique case (row_stat)
            2'b00:   state_d = S_RW;
            2'b01:   state_d = S_ACT;
            default: state_d = S_PRE;
          endcase
        end
      end

      // Precharge waits out tRAS of the row opened by the previous request.
      S_PRE: begin
        if (ras_q == '0) begin
          cmd_c   = CMD_PRE;
          wait_d  = RP_LOAD;
          state_d = S_WAIT_RP;
        end
      end

      S_WAIT_RP: begin
        if (wait_q == '0) state_d = S_ACT;
        else              wait_d  = wait_q - CNT_ONE;
      end

      S_ACT: begin
        cmd_c   = CMD_ACT;
        ras_d   = RAS_LOAD;
        wait_d  = RCD_LOAD;
        state_d = S_WAIT_RCD;
      end

      S_WAIT_RCD: begin
        if (wait_q == '0) state_d = S_RW;
        else              wait_d  = wait_q - CNT_ONE;
      end

      S_RW: begin
        cmd_c   = rw_q ? CMD_WR : CMD_RD;
        wait_d  = DATA_LOAD;
        state_d = S_WAIT_DATA;
      end

      S_WAIT_DATA: begin
        if (wait_q == '0) begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q - CNT_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      ras_q       <= '0;
      rw_q        <= 1'b0;
      bank_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      last_bank_q <= '0;
      last_row_q  <= '0;
      last_col_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      ras_q       <= ras_d;
      rw_q        <= rw_d;
      bank_q      <= bank_d;
      row_q       <= row_d;
      col_q       <= col_d;
      last_bank_q <= cmd_bank;
      last_row_q  <= cmd_row;
      last_col_q  <= cmd_col;
    end
  end

  // Command fields show the captured request while a command is on the bus
  // and otherwise hold whatever was last driven.
  assign cmd       = cmd_c;
  assign cmd_bank  = (cmd_c != CMD_NOP) ? bank_q : last_bank_q;
  assign cmd_row   = (cmd_c == CMD_ACT) ? row_q : last_row_q;
  assign cmd_col   = (cmd_c == CMD_RD || cmd_c == CMD_WR) ? col_q : last_col_q;
  assign done      = done_c;
  assign busy      = (state_q != S_IDLE);
  assign req_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_dram_cmd_fsm.sv
// Bench for dram_cmd_fsm: a cycle-schedule model predicts every output each
// cycle; directed scenarios pin absolute cycles, then a random phase follows.
module tb_dram_cmd_fsm;

  localparam int BANK_W  = 4;
  localparam int ROW_W   = 16;
  localparam int COL_W   = 10;
  localparam int T_RCD   = 4;
  localparam int T_RP    = 4;
  localparam int T_RAS   = 20;
  localparam int T_CL    = 4;
  localparam int T_BURST = 4;

  localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_rw = 1'b0;
  logic [BANK_W-1:0] req_bank = '0;
  logic [ROW_W-1:0]  req_row = '0;
  logic [COL_W-1:0]  req_col = '0;
  logic [1:0]        row_stat = 2'b00;
  logic [2:0]        cmd;
  logic [BANK_W-1:0] cmd_bank;
  logic [ROW_W-1:0]  cmd_row;
  logic [COL_W-1:0]  cmd_col;
  logic              done;
  logic              busy;

  dram_cmd_fsm #(
    .BANK_W(BANK_W), .ROW_W(ROW_W), .COL_W(COL_W), .T_RCD(T_RCD), .T_RP(T_RP),
    .T_RAS(T_RAS), .T_CL(T_CL), .T_BURST(T_BURST)
  ) dut (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .row_stat(row_stat), .cmd(cmd), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
    .cmd_col(cmd_col), .done(done), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model: each accepted request becomes a set of absolute cycle numbers.
  int                m_acc = -1, m_pre = -1, m_act = -1, m_rwc = -1, m_done = -1;
  int                m_ras_ok = 0;
  logic              m_rw = 1'b0;
  logic [BANK_W-1:0] m_bank = '0, m_last_bank = '0;
  logic [ROW_W-1:0]  m_row = '0;
  logic [COL_W-1:0]  m_col = '0;
  logic [2:0]        e_cmd;
  logic              e_busy;

  function automatic bit m_idle_now();
    return !(cyc > m_acc && cyc <= m_done);
  endfunction

  function automatic logic [2:0] m_cmd(input int n);
    if (n == m_pre) return PRE;
    if (n == m_act) return ACT;
    if (n == m_rwc) return m_rw ? WR : RD;
    return NOP;
  endfunction

  always @(negedge CLK) begin
    if (!nRST) begin
      m_acc = -1; m_pre = -1; m_act = -1; m_rwc = -1; m_done = -1;
      m_ras_ok = 0; m_last_bank = '0;
      check("rst_cmd", 32'(cmd), 32'(NOP));
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_bank", 32'(cmd_bank), 32'd0);
      check("rst_row", 32'(cmd_row), 32'd0);
      check("rst_col", 32'(cmd_col), 32'd0);
    end else begin
      e_cmd  = m_cmd(cyc);
      e_busy = (cyc > m_acc) && (cyc <= m_done);
      if (e_cmd != NOP) m_last_bank = m_bank;
      check("cmd", 32'(cmd), 32'(e_cmd));
      check("cmd_bank", 32'(cmd_bank), 32'(m_last_bank));
      if (e_cmd == ACT) check("cmd_row", 32'(cmd_row), 32'(m_row));
      if (e_cmd == RD || e_cmd == WR) check("cmd_col", 32'(cmd_col), 32'(m_col));
      check("done", 32'(done), 32'(cyc == m_done));
      check("busy", 32'(busy), 32'(e_busy));
      check("req_ready", 32'(req_ready), 32'(!e_busy));
      if (req_valid && !e_busy) begin
        m_acc = cyc; m_rw = req_rw; m_bank = req_bank; m_row = req_row; m_col = req_col;
        m_pre = -1; m_act = -1;
        case (row_stat)
          2'b00: m_rwc = cyc + 1;
          2'b01: begin m_act = cyc + 1; m_rwc = m_act + T_RCD; end
          default: begin
            m_pre = (cyc + 1 > m_ras_ok) ? cyc + 1 : m_ras_ok;
            m_act = m_pre + T_RP;
            m_rwc = m_act + T_RCD;
          end
        endcase
        if (m_act >= 0) m_ras_ok = m_act + T_RAS;
        m_done = m_rwc + T_CL + T_BURST;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic at(input int n);
    while (cyc < n) tick();
    @(negedge CLK);
  endtask

  task automatic send(input logic rw, input logic [BANK_W-1:0] bank,
                      input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                      input logic [1:0] stat, output int acc);
    int guard;
    guard = 0;
    req_valid = 1'b0;
    tick();
    while (!m_idle_now() && guard < 100) begin
      tick();
      guard++;
    end
    check("send_idle", 32'(m_idle_now()), 32'd1);
    req_valid = 1'b1; req_rw = rw; req_bank = bank; req_row = row; req_col = col;
    row_stat = stat;
    acc = cyc;
    tick();
    req_valid = 1'b0;
    req_rw = 1'($urandom); req_bank = BANK_W'($urandom); req_row = ROW_W'($urandom);
    req_col = COL_W'($urandom); row_stat = 2'($urandom);
  endtask

  initial begin
    int c, c2;
    at(2);
    check("init_cmd", 32'(cmd), 32'(NOP));
    check("init_ready", 32'(req_ready), 32'd1);
    tick();
    nRST = 1'b1;

    // HIT read
    send(1'b0, 4'd2, 16'h1234, 10'h015, 2'b00, c);
    check("t1_model_done", 32'(m_done - c), 32'd9);
    at(c + 1);
    check("t1_rd", 32'(cmd), 32'(RD));
    check("t1_bank", 32'(cmd_bank), 32'd2);
    check("t1_col", 32'(cmd_col), 32'h15);
    at(c + 8);  check("t1_no_done", 32'(done), 32'd0);
    at(c + 9);  check("t1_done", 32'(done), 32'd1);
    at(c + 10); check("t1_ready", 32'(req_ready), 32'd1);

    // row_stat 11 with tRAS already met behaves as CONFLICT
    send(1'b1, 4'd5, 16'h0abc, 10'h077, 2'b11, c);
    at(c + 1); check("t2_pre", 32'(cmd), 32'(PRE)); check("t2_bank", 32'(cmd_bank), 32'd5);
    at(c + 5); check("t2_act", 32'(cmd), 32'(ACT)); check("t2_row", 32'(cmd_row), 32'h0abc);
    at(c + 9); check("t2_wr", 32'(cmd), 32'(WR)); check("t2_col", 32'(cmd_col), 32'h077);

    // EMPTY write
    send(1'b1, 4'd3, 16'h0012, 10'h040, 2'b01, c);
    at(c + 1);  check("t3_act", 32'(cmd), 32'(ACT)); check("t3_row", 32'(cmd_row), 32'h12);
    at(c + 5);  check("t3_wr", 32'(cmd), 32'(WR)); check("t3_col", 32'(cmd_col), 32'h40);
    at(c + 13); check("t3_done", 32'(done), 32'd1);

    // EMPTY read then CONFLICT stalled by tRAS=20
    send(1'b0, 4'd1, 16'h0100, 10'h008, 2'b01, c);
    send(1'b0, 4'd1, 16'h0200, 10'h009, 2'b10, c2);
    check("t4_acc", 32'(c2 - c), 32'd14);
    at(c + 18); check("t4_stall", 32'(cmd), 32'(NOP)); check("t4_busy", 32'(busy), 32'd1);
    at(c + 21); check("t4_pre", 32'(cmd), 32'(PRE));
    at(c + 25); check("t4_act", 32'(cmd), 32'(ACT)); check("t4_row", 32'(cmd_row), 32'h200);
    at(c + 29); check("t4_rd", 32'(cmd), 32'(RD)); check("t4_col", 32'(cmd_col), 32'h9);

    // new request held during WAIT_DATA is not accepted
    tick();
    req_valid = 1'b1; req_bank = 4'hf; req_row = 16'hffff; req_col = 10'h3ff; row_stat = 2'b00;
    at(c + 32);
    check("t5_not_ready", 32'(req_ready), 32'd0);
    check("t5_bank_hold", 32'(cmd_bank), 32'd1);
    tick();
    while (cyc < c + 35) tick();
    req_valid = 1'b0;
    at(c + 37); check("t5_done", 32'(done), 32'd1);

    // reset during WAIT_RCD
    send(1'b1, 4'd6, 16'h0033, 10'h044, 2'b01, c);
    at(c + 2);
    tick();
    nRST = 1'b0;
    @(negedge CLK);
    check("t6_cmd", 32'(cmd), 32'(NOP));
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ready", 32'(req_ready), 32'd1);
    tick();
    nRST = 1'b1;
    at(c + 20);
    send(1'b0, 4'd7, 16'h0001, 10'h055, 2'b00, c);
    at(c + 1);
    check("t6_rd", 32'(cmd), 32'(RD));
    check("t6_bank", 32'(cmd_bank), 32'd7);
    check("t6_col", 32'(cmd_col), 32'h55);

    // random traffic with occasional resets
    tick();
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_rw    = 1'($urandom);
      req_bank  = BANK_W'($urandom);
      req_row   = ROW_W'($urandom);
      req_col   = COL_W'($urandom);
      row_stat  = 2'($urandom);
      nRST      = ($urandom_range(0, 399) != 0);
      tick();
    end
    nRST = 1'b1;
    req_valid = 1'b0;
    repeat (60) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
